data_mem_responder: RTL and testbench

- Responder side of the CPU data-memory interface. Services the CPU's store and load requests (write strobe, address, store data, size code) and returns load data with the addressed byte at bit 0; the CPU sign- or zero-extends it.
- Backing store is a byte-addressable RAM.
- A small MMIO window provides a console TX FIFO, a status register and a free-running cycle counter.

---
 rtl/data_mem_responder.sv | 140 ++++++++++++++
 tb/tb_data_mem_responder.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Purpose: CPU data-memory responder: byte-addressable RAM plus an MMIO window (console TX FIFO, status, cycle counter).
// Latency: loads are combinational from i_addr; stores, pushes and register writes take effect on the next rising edge.
// Backpressure: console side is valid/ready; a push into a full FIFO with no pop is dropped and sets a sticky overflow flag.
module data_mem_responder #(
    parameter int unsigned DEPTH_BYTES = 4096,
    parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_write,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    input  logic [1:0]  i_memsize,
    output logic [31:0] o_rdata,
    output logic        o_tx_valid,
    output logic [7:0]  o_tx_data,
    input  logic        i_tx_ready
);

    localparam int AW = $clog2(DEPTH_BYTES);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT   = CW'(FIFO_DEPTH);
    localparam logic [15:0]   OFF_TXDATA = 16'h0000;
    localparam logic [15:0]   OFF_STATUS = 16'h0004;
    localparam logic [15:0]   OFF_CYCLE  = 16'h0008;

    logic [7:0]    mem [DEPTH_BYTES];
    logic [AW-1:0] idx [4];
    logic [3:0]    ram_we;

    logic [7:0]    fifo_q [FIFO_DEPTH];
    logic [PW-1:0] rd_ptr, wr_ptr;
    logic [CW-1:0] count;
    logic          ovf;
    logic [31:0]   cycle_cnt;

    logic          is_mmio;
    logic [15:0]   off;
    logic          size_nz;
    logic          push_req, push_ok, push_drop, pop, ovf_clr, cycle_ld;
    logic          tx_full, tx_empty;
    logic [31:0]   status_word;

    assign is_mmio  = (i_addr[31:16] == MMIO_BASE[31:16]);
    assign off      = i_addr[15:0];
    assign size_nz  = (i_memsize != 2'b00);

    assign tx_empty   = (count == '0);
    assign tx_full    = (count == FULL_CNT);
    assign o_tx_valid = !tx_empty;
    // Gate the head byte so the output is 0 while the FIFO is empty (storage is not reset).
    assign o_tx_data  = tx_empty ? 8'h00 : fifo_q[rd_ptr];

    assign pop       = o_tx_valid && i_tx_ready;
    assign push_req  = i_write && is_mmio && (off == OFF_TXDATA) && size_nz;
    assign push_ok   = push_req && (!tx_full || pop);
    assign push_drop = push_req && !push_ok;
    assign ovf_clr   = i_write && is_mmio && (off == OFF_STATUS) && size_nz && i_wdata[2];
    assign cycle_ld  = i_write && is_mmio && (off == OFF_CYCLE) && (i_memsize == 2'b11);

    assign status_word = {16'h0000, 8'(count), 5'b00000, ovf, tx_empty, tx_full};

    // Byte indices of the four lanes; each wraps independently around the RAM.
    always_comb begin
        for (int k = 0; k < 4; k++) begin
            idx[k] = i_addr[AW-1:0] + AW'(k);
        end
    end

    // Per-lane RAM write enables from the size code; MMIO addresses never touch RAM.
    always_comb begin
        ram_we = 4'b0000;
        if (i_write && !is_mmio) begin
            case (i_memsize)
                2'b01:   ram_we = 4'b0001;
                2'b10:   ram_we = 4'b0011;
                2'b11:   ram_we = 4'b1111;
                default: ram_we = 4'b0000;
            endcase
        end
    end

    // RAM store: contents are deliberately left unreset.
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++) begin
            if (ram_we[k]) begin
                mem[idx[k]] <= i_wdata[8*k +: 8];
            end
        end
    end

    // FIFO storage write on an accepted push.
    always_ff @(posedge i_clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr] <= i_wdata[7:0];
        end
    end

    // FIFO pointers, occupancy and sticky overflow; a drop outranks a same-cycle clear.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (push_drop)    ovf <= 1'b1;
            else if (ovf_clr) ovf <= 1'b0;
        end
    end

    // Free-running cycle counter; a full-word write replaces the increment for that cycle.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)         cycle_cnt <= 32'h0;
        else if (cycle_ld) cycle_cnt <= i_wdata;
        else               cycle_cnt <= cycle_cnt + 32'h1;
    end

    // Load path: MMIO register mux or four RAM bytes, addressed byte in [7:0].
    always_comb begin
        o_rdata = {mem[idx[3]], mem[idx[2]], mem[idx[1]], mem[idx[0]]};
        if (is_mmio) begin
            case (off)
                OFF_STATUS: o_rdata = status_word;
                OFF_CYCLE:  o_rdata = cycle_cnt;
                default:    o_rdata = 32'h0;
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose: self-checking bench for data_mem_responder (RAM vectors, TX FIFO scoreboard, cycle counter, reset).
// Latency: inputs change 1ns after the rising edge; outputs sampled mid-cycle.
// Backpressure: i_tx_ready is driven by the bench; popped bytes are checked against an expected-byte queue.
module tb_data_mem_responder;

    localparam int unsigned DEPTH  = 4096;
    localparam logic [31:0] MBASE  = 32'hFFFF_0000;
    localparam logic [31:0] A_TX   = MBASE + 32'h0;
    localparam logic [31:0] A_STAT = MBASE + 32'h4;
    localparam logic [31:0] A_CYC  = MBASE + 32'h8;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_write = 1'b0;
    logic [31:0] i_addr = 32'h0;
    logic [31:0] i_wdata = 32'h0;
    logic [1:0]  i_memsize = 2'b00;
    logic [31:0] o_rdata;
    logic        o_tx_valid;
    logic [7:0]  o_tx_data;
    logic        i_tx_ready = 1'b0;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [1:0]  size;
        logic        chk;
        logic [31:0] exp;
        logic [31:0] mask;
    } vec_t;

    vec_t vecs[$];
    logic [7:0] exp_q[$];

    data_mem_responder #(
        .DEPTH_BYTES(DEPTH),
        .MMIO_BASE  (MBASE),
        .FIFO_DEPTH (4)
    ) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_write   (i_write),
        .i_addr    (i_addr),
        .i_wdata   (i_wdata),
        .i_memsize (i_memsize),
        .o_rdata   (o_rdata),
        .o_tx_valid(o_tx_valid),
        .o_tx_data (o_tx_data),
        .i_tx_ready(i_tx_ready)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr_cyc(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
        i_write = 1'b1; i_addr = a; i_wdata = d; i_memsize = s;
        tick();
        i_write = 1'b0; i_memsize = 2'b00;
    endtask

    task automatic peek(input string name, input logic [31:0] a, input logic [31:0] exp);
        i_write = 1'b0; i_addr = a;
        #2;
        chk(name, o_rdata, exp);
    endtask

    task automatic add(input logic wr, input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                       input logic c, input logic [31:0] e, input logic [31:0] m);
        vec_t v;
        v.wr = wr; v.addr = a; v.wdata = d; v.size = s; v.chk = c; v.exp = e; v.mask = m;
        vecs.push_back(v);
    endtask

    task automatic drain(input string name, input int exp_cycles);
        int n = 0;
        i_tx_ready = 1'b1;
        #1;
        while (o_tx_valid && n < 20) begin
            tick();
            n++;
        end
        i_tx_ready = 1'b0;
        chk({name, "_cycles"}, 32'(n), 32'(exp_cycles));
        chk({name, "_qempty"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: every handshake pops the oldest expected byte.
    always @(negedge i_clk) begin
        if (!i_rst && o_tx_valid && i_tx_ready) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL tx_unexpected: got 0x%02h expected no byte", o_tx_data);
            end else begin
                chk("tx_byte", 32'(o_tx_data), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset and reset-state checks.
        repeat (3) @(posedge i_clk);
        #1;
        chk("rst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("rst_tx_data", 32'(o_tx_data), 32'd0);
        i_rst = 1'b0;
        peek("rst_status", A_STAT, 32'h0000_0002);
        peek("rst_cycle", A_CYC, 32'h0);

        // Cycle counter: 10 edges after reset release.
        repeat (10) tick();
        peek("cycle_10", A_CYC, 32'd10);
        wr_cyc(A_CYC, 32'hFFFF_FFFE, 2'b11);
        peek("cycle_load", A_CYC, 32'hFFFF_FFFE);
        tick();
        peek("cycle_plus1", A_CYC, 32'hFFFF_FFFF);
        tick();
        peek("cycle_wrap", A_CYC, 32'h0000_0000);
        wr_cyc(A_CYC, 32'h0000_1234, 2'b10);
        peek("cycle_halfwr_ignored", A_CYC, 32'h0000_0001);

        // RAM vector table.
        add(1, 32'h10, 32'hDEAD_BEEF, 2'b11, 0, 32'h0, 32'h0);
        add(0, 32'h10, 32'h0, 2'b00, 1, 32'hDEAD_BEEF, 32'hFFFF_FFFF);
        add(0, 32'h11, 32'h0, 2'b00, 1, 32'h00DE_ADBE, 32'h00FF_FFFF);
        add(0, 32'h13, 32'h0, 2'b00, 1, 32'h0000_00DE, 32'h0000_00FF);
        add(1, 32'h12, 32'h0000_0055, 2'b01, 0, 32'h0, 32'h0);
        add(0, 32'h10, 32'h0, 2'b00, 1, 32'hDE55_BEEF, 32'hFFFF_FFFF);
        add(1, DEPTH - 1, 32'h0000_A1B2, 2'b10, 0, 32'h0, 32'h0);
        add(0, DEPTH - 1, 32'h0, 2'b00, 1, 32'h0000_A1B2, 32'h0000_FFFF);
        add(0, 32'h0, 32'h0, 2'b00, 1, 32'h0000_00A1, 32'h0000_00FF);
        add(1, 32'h20, 32'h1234_5678, 2'b11, 0, 32'h0, 32'h0);
        add(1, 32'h20, 32'hFFFF_FFFF, 2'b00, 1, 32'h1234_5678, 32'hFFFF_FFFF);
        add(0, 32'h20, 32'h0, 2'b00, 1, 32'h1234_5678, 32'hFFFF_FFFF);
        add(1, 32'h20, 32'hAABB_CCDD, 2'b11, 1, 32'h1234_5678, 32'hFFFF_FFFF);
        add(0, 32'h20, 32'h0, 2'b00, 1, 32'hAABB_CCDD, 32'hFFFF_FFFF);
        add(1, MBASE + 32'h10, 32'h1122_3344, 2'b11, 1, 32'h0, 32'hFFFF_FFFF);
        add(0, 32'h10, 32'h0, 2'b00, 1, 32'hDE55_BEEF, 32'hFFFF_FFFF);
        add(0, A_TX, 32'h0, 2'b00, 1, 32'h0, 32'hFFFF_FFFF);
        add(0, DEPTH + 32'h10, 32'h0, 2'b00, 1, 32'hDE55_BEEF, 32'hFFFF_FFFF);

        for (int i = 0; i < vecs.size(); i++) begin
            i_write = vecs[i].wr; i_addr = vecs[i].addr;
            i_wdata = vecs[i].wdata; i_memsize = vecs[i].size;
            #2;
            if (vecs[i].chk) chk($sformatf("vec[%0d]", i), o_rdata & vecs[i].mask, vecs[i].exp);
            tick();
            i_write = 1'b0; i_memsize = 2'b00;
        end

        // TX FIFO: fill past full with the consumer stalled.
        i_tx_ready = 1'b0;
        for (int b = 8'h41; b <= 8'h45; b++) begin
            if (b <= 8'h44) exp_q.push_back(8'(b));
            wr_cyc(A_TX, 32'(b), 2'b01);
        end
        peek("fifo_full_status", A_STAT, 32'h0000_0405);
        chk("fifo_head_valid", 32'(o_tx_valid), 32'd1);
        chk("fifo_head_data", 32'(o_tx_data), 32'h41);
        drain("drain1", 4);
        peek("fifo_empty_ovf_status", A_STAT, 32'h0000_0006);
        wr_cyc(A_STAT, 32'h4, 2'b11);
        peek("ovf_cleared_status", A_STAT, 32'h0000_0002);

        // Push into a full FIFO while a pop happens: accepted, no overflow.
        for (int b = 8'h51; b <= 8'h54; b++) begin
            exp_q.push_back(8'(b));
            wr_cyc(A_TX, 32'(b), 2'b01);
        end
        peek("refill_status", A_STAT, 32'h0000_0401);
        i_tx_ready = 1'b1;
        exp_q.push_back(8'h99);
        wr_cyc(A_TX, 32'h99, 2'b01);
        i_tx_ready = 1'b0;
        peek("push_pop_full_status", A_STAT, 32'h0000_0401);
        drain("drain2", 4);

        // Reset in the middle of a drain.
        for (int b = 8'h61; b <= 8'h63; b++) begin
            exp_q.push_back(8'(b));
            wr_cyc(A_TX, 32'(b), 2'b01);
        end
        i_tx_ready = 1'b1;
        tick();
        i_rst = 1'b1;
        #1;
        chk("midrst_tx_valid", 32'(o_tx_valid), 32'd0);
        chk("midrst_tx_data", 32'(o_tx_data), 32'd0);
        peek("midrst_cycle", A_CYC, 32'h0);
        peek("midrst_status", A_STAT, 32'h0000_0002);
        exp_q.delete();
        i_tx_ready = 1'b0;
        tick();
        i_rst = 1'b0;
        tick();
        peek("postrst_cycle", A_CYC, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
